// File: rtl/alu_unit_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: the function codes
// ({funct7[5], funct3}) used by both the decoder and the ALU datapath.
package alu_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_func_e;

endpackage : alu_unit_pkg

// File: rtl/alu_unit_comb.sv
// Purely combinational ALU datapath: result and zero flag from two operands
// and a function code. Shifts use the full 32-bit shift amount, so any
// amount of 32 or more saturates instead of wrapping modulo 32.
module alu_unit_comb
  import alu_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      func,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic            big_shift;
  logic [SHW-1:0]  shamt;

  // Any set bit above the low shift field means the shift moves everything out.
  assign big_shift = |b[XLEN-1:SHW];
  assign shamt     = b[SHW-1:0];

  // Select the operation; undefined codes fall through to zero.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result unassigned, which would infer a latch.
    result = '0;
    case (func)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = big_shift ? '0 : (a << shamt);
      ALU_SRL:  result = big_shift ? '0 : (a >> shamt);
      ALU_SRA:  result = big_shift ? {XLEN{a[XLEN-1]}}
                                   : XLEN'($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule : alu_unit_comb

// File: rtl/alu_unit.sv
// RV32I execute-stage ALU with one registered output stage. A result issued
// with in_valid appears on out one clock later, flagged by out_valid; idle
// cycles hold the last result and its zero flag.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [3:0]      func,
  output logic [XLEN-1:0] out,
  output logic            out_valid,
  output logic            zero
);

  logic [XLEN-1:0] comb_result;
  logic            comb_zero;

  alu_unit_comb #(.XLEN(XLEN)) u_comb (
    .a      (in_a),
    .b      (in_b),
    .func   (func),
    .result (comb_result),
    .zero   (comb_zero)
  );

  // Output registers: capture on valid issue, hold otherwise; valid tracks issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= comb_result;
        zero <= comb_zero;
      end
    end
  end

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: expected results are queued when an
// operation is issued and compared when the registered output appears.
module tb_alu_unit;
  import alu_unit_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  func;
  logic [31:0] out;
  logic        out_valid;
  logic        zero;

  exp_t        sb[$];
  exp_t        last_exp;
  int          total = 0;
  int          bad   = 0;

  alu_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .func      (func),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference model written independently of the RTL (64-bit shift trick for SRA).
  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [3:0] f);
    logic [63:0] w;
    int          sh;
    sh = (b >= 32) ? 32 : int'(b);
    case (f)
      4'b0000: model = a + b;
      4'b1000: model = a + (~b) + 32'd1;
      4'b0001: begin w = {32'b0, a} << sh; model = w[31:0]; end
      4'b0101: begin w = {32'b0, a} >> sh; model = w[31:0]; end
      4'b1101: begin w = {{32{a[31]}}, a} >> sh; model = w[31:0]; end
      4'b0010: model = (($signed(a) < $signed(b))) ? 32'd1 : 32'd0;
      4'b0011: model = (a < b) ? 32'd1 : 32'd0;
      4'b0100: model = a ^ b;
      4'b0110: model = a | b;
      4'b0111: model = a & b;
      default: model = 32'd0;
    endcase
  endfunction

  // Issue one valid operation and queue its expected result; advance to #1 after the edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                       input logic [31:0] expected);
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    func     = f;
    e.res    = expected;
    e.zero   = (expected == 32'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    func     = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, zero, out} !== {1'b1 ^ 1'b1, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL reset_hold: got v=%b z=%b out=%h want v=0 z=1 out=0", out_valid, zero, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, zero, out} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL reset_release: got v=%b z=%b out=%h want v=0 z=1 out=0", out_valid, zero, out);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    logic [31:0] vb[4] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFF};
    logic [3:0]  vf[4] = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB};
    logic [31:0] ve[4] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h80000001};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vf[i], ve[i]);
      e = sb.pop_front();
      last_exp = e;
      total++;
      if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
        bad++;
        $display("FAIL arith[%0d]: got v=%b z=%b out=%h want v=1 z=%b out=%h", i, out_valid, zero, out, e.zero, e.res);
      end
    end
  endtask

  task automatic test_shift();
    logic [31:0] va[7] = '{32'h3, 32'h3, 32'h80F001FF, 32'h80F001FF, 32'h80000000, 32'h1234ABCD, 32'h1234ABCD};
    logic [31:0] vb[7] = '{32'd31, 32'd32, 32'd31, 32'd31, 32'd40, 32'd0, 32'h00010004};
    logic [3:0]  vf[7] = '{ALU_SLL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA, ALU_SRA, ALU_SRL};
    logic [31:0] ve[7] = '{32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234ABCD, 32'h0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vf[i], ve[i]);
      e = sb.pop_front();
      last_exp = e;
      total++;
      if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
        bad++;
        $display("FAIL shift[%0d]: got v=%b z=%b out=%h want v=1 z=%b out=%h", i, out_valid, zero, out, e.zero, e.res);
      end
    end
  endtask

  task automatic test_compare();
    logic [31:0] va[5] = '{32'hFFFFFFFF, 32'h80000000, 32'h3, 32'hFFFFFFFF, 32'h0};
    logic [31:0] vb[5] = '{32'h0, 32'h80000001, 32'h2, 32'h0, 32'hFFFFFFFF};
    logic [3:0]  vf[5] = '{ALU_SLT, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
    logic [31:0] ve[5] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], vf[i], ve[i]);
      e = sb.pop_front();
      last_exp = e;
      total++;
      if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
        bad++;
        $display("FAIL compare[%0d]: got v=%b z=%b out=%h want v=1 z=%b out=%h", i, out_valid, zero, out, e.zero, e.res);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0]  vf[4] = '{ALU_XOR, ALU_OR, ALU_AND, 4'b1111};
    logic [31:0] ve[4] = '{32'hAC0FFF3B, 32'hAF2FFFFB, 32'h032000C0, 32'h0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(32'h032110C0, 32'hAF2EEFFB, vf[i], ve[i]);
      e = sb.pop_front();
      last_exp = e;
      total++;
      if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
        bad++;
        $display("FAIL logic[%0d]: got v=%b z=%b out=%h want v=1 z=%b out=%h", i, out_valid, zero, out, e.zero, e.res);
      end
    end
  endtask

  task automatic test_bubble();
    exp_t e;
    issue(32'h00000010, 32'h00000005, ALU_ADD, 32'h00000015);
    e = sb.pop_front();
    last_exp = e;
    // Idle cycle with changing operands: output must hold, valid must drop.
    in_valid = 1'b0;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h0;
    func     = ALU_AND;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, zero, out} !== {1'b0, last_exp.zero, last_exp.res}) begin
      bad++;
      $display("FAIL bubble_hold: got v=%b z=%b out=%h want v=0 z=%b out=%h", out_valid, zero, out, last_exp.zero, last_exp.res);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes[11] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                               ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, 4'b1010};
    logic [31:0] a, b;
    logic [3:0]  f;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) b = a;
      f = codes[$urandom_range(0, 10)];
      issue(a, b, f, model(a, b, f));
      e = sb.pop_front();
      last_exp = e;
      total++;
      if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
        bad++;
        $display("FAIL b2b[%0d] f=%b a=%h b=%h: got v=%b z=%b out=%h want v=1 z=%b out=%h",
                 i, f, a, b, out_valid, zero, out, e.zero, e.res);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    issue(32'h00000001, 32'h00000001, ALU_ADD, 32'h00000002);
    e = sb.pop_front();
    // Issue another operation, then assert reset before the edge that would capture it.
    in_valid = 1'b1;
    in_a     = 32'h00000007;
    in_b     = 32'h00000001;
    func     = ALU_SUB;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, zero, out} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL reset_async: got v=%b z=%b out=%h want v=0 z=1 out=0", out_valid, zero, out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, zero, out} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL reset_discard: got v=%b z=%b out=%h want v=0 z=1 out=0", out_valid, zero, out);
    end
    issue(32'h00000009, 32'h00000002, ALU_SUB, 32'h00000007);
    e = sb.pop_front();
    total++;
    if ({out_valid, zero, out} !== {1'b1, e.zero, e.res}) begin
      bad++;
      $display("FAIL reset_recover: got v=%b z=%b out=%h want v=1 z=%b out=%h", out_valid, zero, out, e.zero, e.res);
    end
  endtask

  // Watchdog: the run is fixed-length, so this only fires if time runs away.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    last_exp = '0;
    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_logic_ops();
    test_bubble();
    test_back_to_back();
    test_reset_midstream();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_unit
